pipe_skid_chain: RTL
====================

# pipe_skid_chain

- Parametrised elastic pipeline register chain: `STAGES` back-to-back skid-buffered stages carrying a `DW`-bit payload.
- Uses a valid/ready handshake on both ends, plus a synchronous flush.
- Successor to the fixed-field, enable-gated inter-stage registers. It adds backpressure without a combinational ready path, full one-beat-per-cycle throughput, kill-on-flush and an occupancy count.
- Sits between any two pipeline stages, e.g. EX to MEM, or as a fetch buffer ahead of decode.

## Interface
- `DW`, 32, payload width in bits (≥1).
- `STAGES`, 1, number of chained skid stages (≥1).
- `CW`, `$clog2(2*STAGES+1)`, occupancy counter width (derived, not overridden).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  discard every held beat.
- `in_valid_i`  in  1  upstream beat present.
- `in_data_i`  in  DW  upstream payload.
- `in_ready_o`  out  1  chain can accept a beat this cycle.
- `out_valid_o`  out  1  downstream beat present.
- `out_data_o`  out  DW  downstream payload.
- `out_ready_i`  in  1  downstream accepts.
- `count_o`  out  CW  beats currently held, range 0..2*STAGES.

## Operation
- Push at a port: valid & ready high in the same cycle. Pop at a port: valid & ready high in the same cycle.
- Each stage holds a main register and a skid register, each with a valid bit.
- Stage FSM has three states:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - TWO: main and skid valid.
- Stage ready to upstream is `!skid_valid`, driven straight from a flop.
- FSM transitions:
  - EMPTY + push → ONE. Data goes to main.
  - ONE + push + pop → ONE. Main takes the new data.
  - ONE + push, no pop → TWO. Data goes to skid.
  - ONE + pop, no push → EMPTY.
  - TWO + pop → ONE. Skid moves to main; no push is possible in TWO.
  - Any other combination holds state.
- Ordering is strictly FIFO. No beat is duplicated, dropped or reordered except by flush.
- Chaining: stage k `out_*` drives stage k+1 `in_*`. `in_ready_o` comes from stage 0; `out_valid_o`/`out_data_o` come from stage `STAGES-1`.
- `count_o` is an aggregate registered counter:
  - +1 on input push, −1 on output pop, unchanged when both occur.
  - Never wraps. Never exceeds 2*STAGES; exceeding it is an assertion failure in simulation.
- Flush:
  - All valid bits and `count_o` go to 0 at the next edge.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle completes normally; the consumer keeps that beat.
- Reset outranks flush. Flush outranks push/pop.
- Reset:
  - All stages enter EMPTY; payload registers clear to 0.
  - Inputs are ignored during reset.
  - Reset mid-transfer loses all held beats.
- Payload registers load only on push or skid-move; they are not cleared by flush.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=0, `count_o`=0, `in_ready_o`=1 (skid empty).
- All outputs are registered. There is no combinational path from `out_ready_i` to `in_ready_o`, or from `in_valid_i` to `out_valid_o`.
- Latency into an empty chain with `out_ready_i`=1: push at cycle t gives `out_valid_o` at t+STAGES.
- Sustained throughput is 1 beat/cycle with `out_ready_i` held high.
- Backpressure: after `out_ready_i` drops, at most 2*STAGES beats are absorbed. `in_ready_o` falls the cycle after the final skid fills.
- Release: the first pop after a stall re-asserts stage-0 ready no earlier than one cycle per stage traversed.
- After a flush at edge t, `out_valid_o`=0 and `count_o`=0 from t+1. `in_ready_o`=1 from t+1.

## Structure
- Sub-module `pipe_skid_stage` implements one stage (params `DW`), with the same port set minus `count_o`.
  - Its FSM state enum `skid_state_e` {EMPTY, ONE, TWO} lives in shared package `pipe_pkg`.
- `pipe_skid_chain` instantiates `STAGES` copies via generate, plus the counter and flush fan-out.

## Test plan
- Reset, then STAGES=3, DW=32, `out_ready_i`=1. Push 0x11,0x22,0x33 on consecutive cycles → out 0x11,0x22,0x33 at cycles t+3,t+4,t+5; `count_o` peaks at 3.
- STAGES=2, `out_ready_i`=0, push continuously → exactly 4 beats accepted; `in_ready_o`=0 after the 4th; `count_o`=4. Then raise `out_ready_i` → 4 beats out in order, no loss.
- Random `in_valid_i`/`out_ready_i` toggling, 10k beats with an incrementing payload → output sequence is strictly incrementing with no gaps; `count_o` equals pushes minus pops every cycle.
- Chain full (count 4, STAGES=2): `flush_i` pulsed together with `in_valid_i`=1 carrying 0xDEAD → next cycle `out_valid_o`=0, `count_o`=0, `in_ready_o`=1; 0xDEAD never appears.
- Assert `rst_i` with 3 beats held and `flush_i`=1 → next cycle all outputs at reset values. A push of 0x55 after release emerges after STAGES cycles.
- Pop and push in the same cycle with count=1, STAGES=1 → `count_o` stays 1, and the new beat is next on the output.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the skid-buffered pipeline chain
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Occupancy counter width able to represent 0..2*stages inclusive.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_chain_if.sv
// rtl/pipe_skid_chain_if.sv - handshake, flush and occupancy bundle for pipe_skid_chain
interface pipe_skid_chain_if #(
    parameter int DW     = 32,
    parameter int STAGES = 1
) ();
    import pipe_pkg::*;

    localparam int CW = occ_width(STAGES);

    logic          flush_i;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
    logic [CW-1:0] count_o;

    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );

endinterface

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - one skid-buffered elastic stage with registered ready and valid
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i
);

    skid_state_e   state_q;
    skid_state_e   state_d;
    logic [DW-1:0] main_data_q;
    logic [DW-1:0] skid_data_q;
    logic          ready_q;
    logic          valid_q;
    logic          push;
    logic          pop;
    logic          load_main;
    logic          load_skid;
    logic          move_skid;

    // Ready and valid are separate flops so neither output decodes state combinationally.
    assign push        = in_valid_i & ready_q;
    assign pop         = valid_q & out_ready_i;
    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_data_q;

    // Next-state and payload load selection; flush kills every transfer into this stage.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
    end

    // State register with ready/valid flops precomputed from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
            valid_q <= (state_d != EMPTY);
        end
    end

    // Payload registers change only on a push or a skid-to-main move.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            if (load_main) begin
                main_data_q <= in_data_i;
            end else if (move_skid) begin
                main_data_q <= skid_data_q;
            end
            if (load_skid) begin
                skid_data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// rtl/pipe_skid_chain.sv - chain of STAGES skid stages with flush and occupancy count
module pipe_skid_chain
    import pipe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int STAGES = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_skid_chain_if.slave   bus
);

    localparam int             CW        = occ_width(STAGES);
    localparam logic [CW-1:0]  MAX_COUNT = CW'(2 * STAGES);

    logic          link_valid [STAGES+1];
    logic          link_ready [STAGES+1];
    logic [DW-1:0] link_data  [STAGES+1];
    logic          kill;
    logic          in_push;
    logic          out_pop;
    logic [CW-1:0] count_q;

    assign kill               = bus.flush_i;
    assign link_valid[0]      = bus.in_valid_i;
    assign link_data[0]       = bus.in_data_i;
    assign link_ready[STAGES] = bus.out_ready_i;
    assign bus.in_ready_o     = link_ready[0];
    assign bus.out_valid_o    = link_valid[STAGES];
    assign bus.out_data_o     = link_data[STAGES];
    assign bus.count_o        = count_q;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            pipe_skid_stage #(.DW(DW)) u_stage (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .flush_i     (kill),
                .in_valid_i  (link_valid[k]),
                .in_data_i   (link_data[k]),
                .in_ready_o  (link_ready[k]),
                .out_valid_o (link_valid[k+1]),
                .out_data_o  (link_data[k+1]),
                .out_ready_i (link_ready[k+1])
            );
        end
    endgenerate

    assign in_push = link_valid[0] & link_ready[0];
    assign out_pop = link_valid[STAGES] & link_ready[STAGES];

    // Aggregate occupancy: pushes at the head minus pops at the tail, cleared by flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (kill) begin
            count_q <= '0;
        end else if (in_push && !out_pop) begin
            count_q <= count_q + 1'b1;
        end else if (!in_push && out_pop) begin
            count_q <= count_q - 1'b1;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= MAX_COUNT);

endmodule
